// File: rtl/dma_copy_m1.sv
// Word-copy DMA engine on the system bus arbiter's second master port (m1).
// Copies len words from src_addr to dst_addr, one read then one write per word.

`ifndef UNSIGNED
`define UNSIGNED 1'b1
`endif
`ifndef BYTE_SEL
`define BYTE_SEL 3:0
`endif
`ifndef SL_WORD
`define SL_WORD 4'b1111
`endif
`ifndef SL_NONE
`define SL_NONE 4'b0000
`endif

module dma_copy_m1 #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             m1_gnt,
  input  logic [31:0]      m1_rdata,
  output logic             m1_un_sign_o,
  output logic [`BYTE_SEL] m1_byte_mask_o,
  output logic             m1_re_o,
  output logic             m1_we_o,
  output logic [31:0]      m1_addr_o,
  output logic [31:0]      m1_wdata_o
);

  typedef enum logic [2:0] {StIdle, StRd, StRwait, StWr, StFin} state_e;

  localparam logic [1:0] LatLast = 2'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       lat_q, lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             re_q, re_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [`BYTE_SEL] mask_q, mask_d;
  logic             misaligned;
  logic             active;

  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign active     = (state_q == StRd) || (state_q == StRwait) || (state_q == StWr);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    re_d    = re_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (abort && active) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      re_d    = 1'b0;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          re_d   = 1'b0;
          we_d   = 1'b0;
          busy_d = 1'b0;
          if (start && !abort) begin
            if (misaligned) begin
              err_d = 1'b1;
            end else if (len == '0) begin
              state_d = StFin;
              done_d  = 1'b1;
            end else begin
              state_d = StRd;
              src_d   = src_addr;
              dst_d   = dst_addr;
              rem_d   = len;
              busy_d  = 1'b1;
              re_d    = 1'b1;
              addr_d  = src_addr;
            end
          end
        end
        StRd: begin
          // Entered from WR with re low, giving the arbiter one idle cycle.
          if (re_q && m1_gnt) begin
            state_d = StRwait;
            re_d    = 1'b0;
            lat_d   = 2'd0;
          end else begin
            re_d   = 1'b1;
            addr_d = src_q;
          end
        end
        StRwait: begin
          if (lat_q == LatLast) begin
            state_d = StWr;
            we_d    = 1'b1;
            addr_d  = dst_q;
            wdata_d = m1_rdata;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        StWr: begin
          if (we_q && m1_gnt) begin
            we_d  = 1'b0;
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = StFin;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = StRd;
              addr_d  = src_q + 32'd4;
            end
          end else begin
            we_d = 1'b1;
          end
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    mask_d = (re_d || we_d) ? `SL_WORD : `SL_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= `SL_NONE;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign m1_un_sign_o   = `UNSIGNED;
  assign m1_byte_mask_o = mask_q;
  assign m1_re_o        = re_q;
  assign m1_we_o        = we_q;
  assign m1_addr_o      = addr_q;
  assign m1_wdata_o     = wdata_q;

endmodule

// File: tb/tb_dma_copy_m1.sv
// Scoreboard bench for dma_copy_m1: a memory/arbiter model answers m1, the reference
// model predicts every read address, write and completion event at start time.

module tb_dma_copy_m1;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned RD_LAT = 1;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy_o, done_o, err_o;
  logic             m1_gnt = 1'b0;
  logic [31:0]      m1_rdata = 32'h0;
  logic             m1_un_sign_o;
  logic [3:0]       m1_byte_mask_o;
  logic             m1_re_o, m1_we_o;
  logic [31:0]      m1_addr_o, m1_wdata_o;

  dma_copy_m1 #(.LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .m1_gnt         (m1_gnt),
    .m1_rdata       (m1_rdata),
    .m1_un_sign_o   (m1_un_sign_o),
    .m1_byte_mask_o (m1_byte_mask_o),
    .m1_re_o        (m1_re_o),
    .m1_we_o        (m1_we_o),
    .m1_addr_o      (m1_addr_o),
    .m1_wdata_o     (m1_wdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected DUT output, expected none (cycle %0d)", name, cyc);
  endtask

  // Word memory behind the arbiter; unwritten words read a fixed address pattern.
  bit [31:0] mem [bit [31:0]];
  function automatic bit [31:0] mrd(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  typedef struct packed {
    bit [31:0] a;
    bit [31:0] dat;
  } wr_t;

  bit [31:0] exp_rd[$];
  wr_t       exp_wr[$];
  int        exp_ev[$];   // 1 = done, 2 = err

  int busy_cnt, req_cnt, done_cyc, err_cyc, start_cyc;

  // Arbiter + memory slave, driven at the falling edge.
  int unsigned gnt_mode = 0;  // 0: always grant, 1: random grant with m0 contention
  int unsigned gnt_hold = 0;
  int          rd_due[$];
  bit [31:0]   rd_adr[$];
  bit [31:0]   m0_gold [64];
  int          m0_n = 0;

  always @(negedge clk) begin : slave
    bit g;
    int idx;
    bit [31:0] d;
    m1_rdata = $urandom;
    while (rd_due.size() > 0 && rd_due[0] < cyc) begin
      void'(rd_due.pop_front());
      void'(rd_adr.pop_front());
    end
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      m1_rdata = mrd(rd_adr[0]);
      void'(rd_due.pop_front());
      void'(rd_adr.pop_front());
    end
    if ((m1_re_o || m1_we_o) && gnt_hold > 0) begin
      g = 1'b0;
      gnt_hold--;
    end else if (gnt_mode == 0) begin
      g = 1'b1;
    end else begin
      g = ($urandom_range(0, 1) == 1);
    end
    m1_gnt = g;
    if (g && m1_re_o) begin
      rd_due.push_back(cyc + RD_LAT);
      rd_adr.push_back(m1_addr_o);
    end
    if (g && m1_we_o) mem[m1_addr_o] = m1_wdata_o;
    // The core (m0) takes every cycle m1 is not granted.
    if (gnt_mode == 1 && !(g && (m1_re_o || m1_we_o))) begin
      idx = m0_n % 64;
      d = $urandom;
      mem[32'(32'h8000 + 4 * idx)] = d;
      m0_gold[idx] = d;
      m0_n++;
    end
  end

  // Monitor: compares bus activity and events against the scoreboard queues.
  bit        p_re, p_we, p_gnt, p_exempt;
  bit [31:0] p_addr, p_wdata;

  task automatic pop_ev(input string name, input int code);
    if (exp_ev.size() == 0) unexp(name);
    else chk(name, 64'(code), 64'(exp_ev.pop_front()));
  endtask

  always @(negedge clk) begin : monitor
    wr_t w;
    #1;
    if (rst) begin
      p_re = 1'b0; p_we = 1'b0; p_gnt = 1'b0; p_exempt = 1'b1;
    end else begin
      chk("re_we_exclusive", 64'(m1_re_o & m1_we_o), 64'(0));
      chk("byte_mask", 64'(m1_byte_mask_o), (m1_re_o || m1_we_o) ? 64'hF : 64'h0);
      if (p_gnt && (p_re || p_we))
        chk("idle_gap", 64'({m1_re_o, m1_we_o}), 64'(0));
      if (!p_exempt && !p_gnt && (p_re || p_we)) begin
        chk("hold_ctl", 64'({m1_re_o, m1_we_o}), 64'({p_re, p_we}));
        chk("hold_addr", 64'(m1_addr_o), 64'(p_addr));
        if (p_we) chk("hold_wdata", 64'(m1_wdata_o), 64'(p_wdata));
      end
      if (m1_re_o && m1_gnt) begin
        if (exp_rd.size() == 0) unexp("read_access");
        else chk("read_addr", 64'(m1_addr_o), 64'(exp_rd.pop_front()));
      end
      if (m1_we_o && m1_gnt) begin
        if (exp_wr.size() == 0) unexp("write_access");
        else begin
          w = exp_wr.pop_front();
          chk("write_addr", 64'(m1_addr_o), 64'(w.a));
          chk("write_data", 64'(m1_wdata_o), 64'(w.dat));
        end
      end
      if (done_o) begin
        done_cyc = cyc;
        pop_ev("done_event", 1);
        chk("busy_at_done", 64'(busy_o), 64'(0));
      end
      if (err_o) begin
        err_cyc = cyc;
        pop_ev("err_event", 2);
      end
      if (busy_o) busy_cnt++;
      if (m1_re_o || m1_we_o) req_cnt++;
      p_re = m1_re_o; p_we = m1_we_o; p_gnt = m1_gnt;
      p_addr = m1_addr_o; p_wdata = m1_wdata_o;
      p_exempt = abort;
    end
  end

  // Reference model: a copy of l words is l reads at s+4i and l writes of those words to d+4i.
  task automatic launch(input bit [31:0] s, input bit [31:0] d, input int unsigned l,
                        input bit push);
    wr_t w;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = LEN_W'(l); start = 1'b1;
    busy_cnt = 0; req_cnt = 0; start_cyc = cyc;
    if (push) begin
      if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
        exp_ev.push_back(2);
      end else begin
        for (int unsigned i = 0; i < l; i++) begin
          exp_rd.push_back(s + 32'(4 * i));
          w.a = d + 32'(4 * i);
          w.dat = mrd(s + 32'(4 * i));
          exp_wr.push_back(w);
        end
        exp_ev.push_back(1);
      end
    end
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit noise);
    int n = 0;
    while (!(exp_ev.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0 && !busy_o)) begin
      if (n == budget) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d pending items after %0d cycles, expected 0",
                 exp_ev.size() + exp_wr.size() + exp_rd.size(), budget);
        exp_ev.delete(); exp_wr.delete(); exp_rd.delete();
        break;
      end
      @(negedge clk);
      n++;
      start = noise && busy_o && ($urandom_range(0, 3) == 0);
      if (start) begin
        src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wcnt;
    int bad;
    bit [31:0] s, d;
    int unsigned l, kind;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_req", 64'({m1_re_o, m1_we_o}), 64'(0));
    chk("rst_addr", 64'(m1_addr_o), 64'(0));
    chk("rst_wdata", 64'(m1_wdata_o), 64'(0));
    chk("rst_mask", 64'(m1_byte_mask_o), 64'(0));
    chk("un_sign", 64'(m1_un_sign_o), 64'(1));
    rst = 1'b0;

    // Four-word copy, grant always high.
    for (int i = 0; i < 4; i++) mem[32'(32'h100 + 4 * i)] = $urandom;
    launch(32'h100, 32'h200, 4, 1'b1);
    wait_idle(100, 1'b0);
    chk("copy4_done_latency", 64'(done_cyc - start_cyc), 64'(16));
    chk("copy4_busy_cycles", 64'(busy_cnt), 64'(15));
    chk("copy4_bus_cycles", 64'(req_cnt), 64'(8));
    for (int i = 0; i < 4; i++)
      chk("copy4_mem", 64'(mrd(32'(32'h200 + 4 * i))), 64'(mrd(32'(32'h100 + 4 * i))));

    // Zero-length copy.
    launch(32'h300, 32'h400, 0, 1'b1);
    wait_idle(20, 1'b0);
    chk("len0_done_latency", 64'(done_cyc - start_cyc), 64'(1));
    chk("len0_bus_cycles", 64'(req_cnt), 64'(0));
    chk("len0_busy_cycles", 64'(busy_cnt), 64'(0));

    // Misaligned source, then misaligned destination.
    launch(32'h102, 32'h200, 3, 1'b1);
    wait_idle(20, 1'b0);
    chk("misalign_src_err_latency", 64'(err_cyc - start_cyc), 64'(1));
    chk("misalign_src_busy", 64'(busy_cnt), 64'(0));
    chk("misalign_src_bus", 64'(req_cnt), 64'(0));
    launch(32'h100, 32'h401, 3, 1'b1);
    wait_idle(20, 1'b0);
    chk("misalign_dst_bus", 64'(req_cnt), 64'(0));

    // Read grant withheld for 5 cycles.
    mem[32'h500] = $urandom;
    gnt_hold = 5;
    launch(32'h500, 32'h600, 1, 1'b1);
    wait_idle(50, 1'b0);
    chk("gnt_hold_bus_cycles", 64'(req_cnt), 64'(7));
    chk("gnt_hold_mem", 64'(mrd(32'h600)), 64'(mrd(32'h500)));

    // Source address wraps past 2^32.
    launch(32'hFFFF_FFFC, 32'h700, 2, 1'b1);
    wait_idle(50, 1'b0);
    chk("wrap_mem1", 64'(mrd(32'h704)), 64'(mrd(32'h0)));

    // Abort together with start in IDLE.
    @(negedge clk);
    src_addr = 32'h100; dst_addr = 32'h800; len = LEN_W'(2);
    start = 1'b1; abort = 1'b1; busy_cnt = 0; req_cnt = 0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_start_busy", 64'(busy_cnt), 64'(0));
    chk("abort_start_bus", 64'(req_cnt), 64'(0));

    // Abort during the second write of an eight-word copy.
    for (int i = 0; i < 8; i++) begin
      mem[32'(32'h2000 + 4 * i)] = $urandom;
      mem[32'(32'h5000 + 4 * i)] = 32'hDEAD_0000 + 32'(i);
    end
    for (int i = 0; i < 2; i++) begin
      wr_t w;
      exp_rd.push_back(32'(32'h2000 + 4 * i));
      w.a = 32'(32'h5000 + 4 * i);
      w.dat = mrd(32'(32'h2000 + 4 * i));
      exp_wr.push_back(w);
    end
    launch(32'h2000, 32'h5000, 8, 1'b0);
    wcnt = 0;
    for (int n = 0; n < 50 && wcnt < 2; n++) begin
      if (m1_we_o) begin
        wcnt++;
        if (wcnt == 2) abort = 1'b1;
      end
      if (wcnt < 2) @(negedge clk);
    end
    chk("abort_reached_wr2", 64'(wcnt), 64'(2));
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_next", 64'(busy_o), 64'(0));
    chk("abort_req_next", 64'({m1_re_o, m1_we_o}), 64'(0));
    repeat (8) @(negedge clk);
    chk("abort_writes_seen", 64'(exp_wr.size()), 64'(0));
    for (int i = 0; i < 2; i++)
      chk("abort_written", 64'(mrd(32'(32'h5000 + 4 * i))), 64'(mrd(32'(32'h2000 + 4 * i))));
    for (int i = 2; i < 8; i++)
      chk("abort_untouched", 64'(mrd(32'(32'h5000 + 4 * i))), 64'(32'hDEAD_0000 + 32'(i)));
    exp_rd.delete(); exp_wr.delete(); exp_ev.delete();

    // Reset in the middle of a transfer.
    launch(32'h900, 32'hA00, 8, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_req", 64'({m1_re_o, m1_we_o}), 64'(0));
    chk("midrst_addr", 64'(m1_addr_o), 64'(0));
    rst = 1'b0;
    exp_rd.delete(); exp_wr.delete(); exp_ev.delete();
    repeat (2) @(negedge clk);

    // Random transfers against m0 contention, with stray start pulses while busy.
    gnt_mode = 1;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      s = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      d = 32'h4000 + 32'($urandom_range(0, 255)) * 4;
      l = $urandom_range(1, 6);
      if (kind == 0) s[1:0] = 2'($urandom_range(1, 3));
      if (kind == 1) l = 0;
      if (kind == 2) d[1] = 1'b1;
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 1) == 1) mem[s + 32'(4 * i)] = $urandom;
      launch(s, d, l, 1'b1);
      wait_idle(400, 1'b1);
    end
    gnt_mode = 0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 64 && i < m0_n; i++)
      if (mrd(32'(32'h8000 + 4 * i)) != m0_gold[i]) bad++;
    chk("m0_traffic_mem", 64'(bad), 64'(0));
    checks++;
    if (m0_n == 0) begin
      errors++;
      $display("FAIL m0_traffic_count: got 0 core accesses, expected at least 1");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
